// File: rtl/alu_pc_decode_unit_pkg.sv
// Shared definitions for the ALU / program-counter / instruction-decode unit.
// Holds the ALU operation codes, the default datapath widths and the bit
// positions of the instruction-register fields.
// Optional feature macro used by this slice: ALU_SHIFT_EN (enables the shifter).
package alu_pc_decode_unit_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int PC_W_DEF   = 6;

  // Instruction register layout: [9:7] Y reg, [6:4] X reg, [3:0] opcode
  localparam int IR_W      = 10;
  localparam int IR_Y_MSB  = 9;
  localparam int IR_Y_LSB  = 7;
  localparam int IR_X_MSB  = 6;
  localparam int IR_X_LSB  = 4;
  localparam int IR_OP_MSB = 3;
  localparam int IR_OP_LSB = 0;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_SLT = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101
  } alu_op_e;

endpackage

// File: rtl/alu_pc_decode_unit_if.sv
// Bundle of the unit's bus signals, used by the surrounding environment to
// drive and observe the unit.
//   master : drives ALU operands/op, counter controls and the instruction word
//   slave  : drives ALU result, program counter and decoded selects
// Clock and reset are kept outside the bundle.
interface alu_pc_decode_unit_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 6
);
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;
  logic              pc_en;
  logic              pc_incr;
  logic              pc_load;
  logic [PC_W-1:0]   pc_data;
  logic [PC_W-1:0]   pc;
  logic [9:0]        ir;
  logic [7:0]        xsel;
  logic [7:0]        ysel;
  logic [3:0]        opcode;

  modport master (
    output alu_op, alu_a, alu_b, pc_en, pc_incr, pc_load, pc_data, ir,
    input  alu_out, pc, xsel, ysel, opcode
  );

  modport slave (
    input  alu_op, alu_a, alu_b, pc_en, pc_incr, pc_load, pc_data, ir,
    output alu_out, pc, xsel, ysel, opcode
  );
endinterface

// File: rtl/alu_pc_decode_unit_dec3to8.sv
// 3-to-8 one-hot decoder with enable.
//   sel : 3-bit field value
//   en  : when low all outputs are low
//   out : one-hot select; value i drives bit 7-i (value 0 -> leftmost bit)
module dec3to8 (
  input  logic [2:0] sel,
  input  logic       en,
  output logic [7:0] out
);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_dec
      // Reversed bit order: register 0 sits in the MSB position
      assign out[7-gi] = en & (sel == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/alu_pc_decode_unit.sv
// ALU, program counter and instruction-field decoder.
// Ports:
//   Clock            : single clock, rising edge
//   Resetn           : synchronous reset, active HIGH despite the name
//   alu_op/a/b       : ALU op select and operands (b is the bus value)
//   alu_out          : combinational ALU result
//   pc_en/incr/load  : counter enable, increment and load requests
//   pc_data          : counter load value
//   pc               : registered program counter
//   ir               : instruction word {Y[2:0], X[2:0], opcode[3:0]}
//   xsel/ysel        : one-hot register selects, opcode : ir[3:0]
// Macro ALU_SHIFT_EN: when defined, ops 100/101 perform logical shifts by
// alu_b[3:0]; otherwise they return 0 and no shifter is built.
module alu_pc_decode_unit
  import alu_pc_decode_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] alu_a,
  input  logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] alu_out,
  input  logic              pc_en,
  input  logic              pc_incr,
  input  logic              pc_load,
  input  logic [PC_W-1:0]   pc_data,
  output logic [PC_W-1:0]   pc,
  input  logic [IR_W-1:0]   ir,
  output logic [7:0]        xsel,
  output logic [7:0]        ysel,
  output logic [3:0]        opcode
);

  // ---------------- ALU (combinational) ----------------
  logic slt_c;
  assign slt_c = $signed(alu_a) < $signed(alu_b);

  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD: alu_out = alu_a + alu_b;
      ALU_SUB: alu_out = alu_a - alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_SLT: alu_out = {{(DATA_W-1){1'b0}}, slt_c};
`ifdef ALU_SHIFT_EN
      ALU_SLL: alu_out = alu_a << alu_b[3:0];
      ALU_SRL: alu_out = alu_a >> alu_b[3:0];
`endif
      default: alu_out = '0;
    endcase
  end

  // ---------------- Program counter ----------------
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;

  // Load beats increment; disabled counter ignores both.
  always_comb begin
    pc_d = pc_q;
    if (pc_en) begin
      if (pc_load)      pc_d = pc_data;
      else if (pc_incr) pc_d = pc_q + PC_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Resetn) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc = pc_q;

  // ---------------- Instruction decode ----------------
  dec3to8 u_dec_x (
    .sel (ir[IR_X_MSB:IR_X_LSB]),
    .en  (1'b1),
    .out (xsel)
  );

  dec3to8 u_dec_y (
    .sel (ir[IR_Y_MSB:IR_Y_LSB]),
    .en  (1'b1),
    .out (ysel)
  );

  assign opcode = ir[IR_OP_MSB:IR_OP_LSB];

endmodule

// File: tb/tb_alu_pc_decode_unit.sv
// Self-checking bench for alu_pc_decode_unit: directed vectors plus random
// vectors compared against an arithmetic reference model.
module tb_alu_pc_decode_unit;

  localparam int DW = 16;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_pc_decode_unit_if #(.DATA_W(DW), .PC_W(PW)) bif ();

  alu_pc_decode_unit #(.DATA_W(DW), .PC_W(PW)) dut (
    .Clock   (clk),
    .Resetn  (rst),
    .alu_op  (bif.alu_op),
    .alu_a   (bif.alu_a),
    .alu_b   (bif.alu_b),
    .alu_out (bif.alu_out),
    .pc_en   (bif.pc_en),
    .pc_incr (bif.pc_incr),
    .pc_load (bif.pc_load),
    .pc_data (bif.pc_data),
    .pc      (bif.pc),
    .ir      (bif.ir),
    .xsel    (bif.xsel),
    .ysel    (bif.ysel),
    .opcode  (bif.opcode)
  );

  int checks = 0;
  int errors = 0;
  int pc_m   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    $display("chk %-10s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic
  function automatic int alu_ref(input int op, input int a, input int b);
    int sa, sb;
    longint t;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    case (op)
      0: return (a + b) % 65536;
      1: return (a - b + 65536) % 65536;
      2: return a | b;
      3: return (sa < sb) ? 1 : 0;
`ifdef ALU_SHIFT_EN
      4: begin t = longint'(a) * (longint'(1) << (b % 16)); return int'(t % 65536); end
      5: return a / (1 << (b % 16));
`endif
      default: return 0;
    endcase
  endfunction

  task automatic alu_chk(input int op, input int a, input int b, input string tag);
    bif.alu_op = 3'(op);
    bif.alu_a  = 16'(a);
    bif.alu_b  = 16'(b);
    #1;
    check(tag, 32'(bif.alu_out), 32'(alu_ref(op, a, b)));
  endtask

  task automatic pc_step(input bit r, input bit en, input bit inc, input bit ld,
                         input int d, input string tag);
    rst = r;
    bif.pc_en = en; bif.pc_incr = inc; bif.pc_load = ld; bif.pc_data = 6'(d);
    if (r)        pc_m = 0;
    else if (!en) pc_m = pc_m;
    else if (ld)  pc_m = d % 64;
    else if (inc) pc_m = (pc_m + 1) % 64;
    @(posedge clk);
    #1;
    check(tag, 32'(bif.pc), 32'(pc_m));
  endtask

  task automatic dec_chk(input int w, input string tag);
    int y, x;
    bif.ir = 10'(w);
    #1;
    y = (w / 128) % 8;
    x = (w / 16) % 8;
    check({tag, "_y"}, 32'(bif.ysel), 32'(1 << (7 - y)));
    check({tag, "_x"}, 32'(bif.xsel), 32'(1 << (7 - x)));
    check({tag, "_op"}, 32'(bif.opcode), 32'(w % 16));
  endtask

  initial begin
    rst = 1'b1;
    bif.alu_op = 3'd0; bif.alu_a = '0; bif.alu_b = '0;
    bif.pc_en = 1'b0; bif.pc_incr = 1'b0; bif.pc_load = 1'b0; bif.pc_data = '0;
    bif.ir = '0;

    // Reset, then combinational outputs while reset is held
    pc_step(1, 1, 1, 1, 21, "rst");
    pc_step(1, 0, 0, 0, 0,  "rst2");
    alu_chk(0, 'h1234, 'h0101, "alu_in_rst");
    dec_chk('b110_001_1010, "dec_in_rst");
    if (bif.alu_out !== 16'h1335) begin
      errors++; checks++;
      $error("FAIL alu_rst_const observed=%0h expected=1335", bif.alu_out);
    end else checks++;

    // Directed ALU vectors
    alu_chk(0, 'hFFFF, 'h0001, "add_wrap");
    alu_chk(1, 'h0003, 'h0005, "sub_wrap");
    alu_chk(3, 'h8000, 'h0001, "slt_neg");
    alu_chk(3, 'h0001, 'h8000, "slt_swap");
    alu_chk(2, 'hA050, 'h0F0F, "or");
    alu_chk(4, 'h0001, 'h0013, "sll");
    alu_chk(5, 'h8000, 'h000F, "srl");
    alu_chk(6, 'hFFFF, 'hFFFF, "op6");
    alu_chk(7, 'h1234, 'h4321, "op7");

    // Random ALU vectors
    for (int i = 0; i < 40; i++)
      alu_chk(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 65535)), "alu_rnd");

    // Counter: count to 63, wrap, load beats incr
    pc_step(0, 1, 0, 0, 0, "idle");
    for (int i = 0; i < 63; i++) pc_step(0, 1, 1, 0, 0, "incr");
    check("pc63", 32'(bif.pc), 32'd63);
    pc_step(0, 1, 1, 0, 0, "wrap");
    pc_step(0, 1, 1, 1, 'h2A, "ld_incr");
    pc_step(0, 0, 1, 0, 0, "hold_en0");
    pc_step(0, 0, 0, 1, 5, "hold_ld");
    pc_step(0, 1, 1, 0, 0, "incr2");
    pc_step(1, 1, 0, 1, 'h15, "rst_ld");
    pc_step(0, 1, 0, 1, 'h3F, "ld_max");
    pc_step(1, 1, 1, 0, 0, "rst_incr");

    // Random counter steps (reset rarely)
    for (int i = 0; i < 30; i++)
      pc_step(($urandom_range(0, 9) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 63)), "pc_rnd");

    // Decode
    rst = 1'b0;
    dec_chk('b011_101_0110, "dec_dir");
    dec_chk('b000_111_0000, "dec_edge");
    for (int i = 0; i < 8; i++) dec_chk(int'($urandom_range(0, 1023)), "dec_rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pc_decode_unit.md
ALU_PC_DECODE_UNIT -- requirements
Module: alu_pc_decode_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, giving the ALU operand and result width.
REQ-002 The block SHALL have parameter PC_W, default 6, giving the program-counter width.
REQ-003 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Resetn, input, 1 bit: reset, synchronous and active-high (despite the name).
REQ-005 The block SHALL have port alu_op, input, 3 bits: ALU operation select.
REQ-006 The block SHALL have ports alu_a and alu_b, input, DATA_W bits each: ALU operands A and B (B is the bus value).
REQ-007 The block SHALL have port alu_out, output, DATA_W bits: combinational ALU result.
REQ-008 The block SHALL have port pc_en, input, 1 bit: counter clock enable.
REQ-009 The block SHALL have port pc_incr, input, 1 bit: increment request.
REQ-010 The block SHALL have port pc_load, input, 1 bit: parallel-load request.
REQ-011 The block SHALL have port pc_data, input, PC_W bits: load value (bus bits [PC_W-1:0]).
REQ-012 The block SHALL have port pc, output, PC_W bits: registered program counter.
REQ-013 The block SHALL have port ir, input, 10 bits: instruction fields; [9:7] Y register, [6:4] X register, [3:0] opcode.
REQ-014 The block SHALL have ports xsel and ysel, output, 8 bits each: one-hot register selects decoded from ir[6:4] and ir[9:7].
REQ-015 The block SHALL have port opcode, output, 4 bits: equal to ir[3:0].

Function
REQ-016 alu_op 000 SHALL give alu_out = alu_a + alu_b, modulo 2^DATA_W, with carry discarded.
REQ-017 alu_op 001 SHALL give alu_out = alu_a - alu_b, modulo 2^DATA_W (two's complement wrap).
REQ-018 alu_op 010 SHALL give alu_out = alu_a | alu_b (bitwise OR).
REQ-019 alu_op 011 SHALL give alu_out = 1 if alu_a < alu_b as signed two's complement values, else 0, zero-extended to DATA_W.
REQ-020 alu_op 100 SHALL give alu_out = alu_a << alu_b[3:0] (logical left shift); alu_op 101 SHALL give alu_out = alu_a >> alu_b[3:0] (logical right shift, zero fill).
REQ-021 alu_op 110 and 111 SHALL give alu_out = 0.
REQ-022 The ALU SHALL be purely combinational, with zero cycles of latency.
REQ-023 Counter priority per rising edge SHALL be: reset, then pc_en=0 (hold), then pc_load (pc <= pc_data), then pc_incr (pc <= pc+1), else hold.
REQ-024 When pc_load and pc_incr are both high, the load SHALL win; the loaded value takes effect on the next edge with no increment applied.
REQ-025 An increment from 2^PC_W-1 SHALL wrap pc to 0.
REQ-026 Each decoder SHALL drive exactly one output bit high; field value 0 SHALL drive bit 7 (leftmost) high and value 7 SHALL drive bit 0 high (select index i maps to bit 7-i).
REQ-027 The decoders and the opcode output SHALL be combinational.

Reset
REQ-028 When Resetn is high at a rising edge, pc SHALL become 0, regardless of pc_en, pc_load and pc_incr.
REQ-029 A reset arriving mid-count SHALL override a simultaneous load or increment.
REQ-030 The combinational outputs (alu_out, xsel, ysel, opcode) SHALL not be affected by reset.

Configuration
REQ-031 With macro ALU_SHIFT_EN defined, alu_op 100 and 101 SHALL perform the shifts of REQ-020.
REQ-032 Without ALU_SHIFT_EN, alu_op 100 and 101 SHALL give alu_out = 0, and no shifter logic SHALL be synthesized.

Structure
REQ-033 A shared package SHALL hold the ALU op codes (ALU_ADD=000, ALU_SUB=001, ALU_OR=010, ALU_SLT=011, ALU_SLL=100, ALU_SRL=101), the default widths, and the ir field bit positions.
REQ-034 The design SHALL have one sub-module, dec3to8 (3-bit input, enable, 8-bit one-hot output), instantiated twice with enable tied high.

Verification
REQ-035 Add and sub: alu_a=0xFFFF, alu_b=0x0001, op 000 -> alu_out 0x0000; alu_a=0x0003, alu_b=0x0005, op 001 -> alu_out 0xFFFE.
REQ-036 Signed slt: alu_a=0x8000, alu_b=0x0001, op 011 -> alu_out 0x0001; operands swapped -> alu_out 0x0000.
REQ-037 Shifts (macro defined): alu_a=0x0001, alu_b=0x0013, op 100 -> alu_out 0x0008; alu_a=0x8000, alu_b=0x000F, op 101 -> alu_out 0x0001; without the macro -> alu_out 0x0000.
REQ-038 Counter wrap and priority: reset -> pc 0; 63 increments -> pc 63; one more increment -> pc 0; load and incr together with pc_data=0x2A -> pc 0x2A.
REQ-039 Hold and reset override: pc_en=0 with pc_incr=1 -> pc unchanged; Resetn=1 together with pc_load=1 -> pc 0.
REQ-040 Decode: ir=10'b011_101_0110 -> ysel 8'b00010000, xsel 8'b00000100, opcode 4'b0110.
